inst_axi_bridge: RTL and testbench
==================================

Name: inst_axi_bridge

Overview:
Instruction-side bus bridge sitting directly upstream of the fetch stage. It turns the PC register's fetch request into a single-beat AXI4 read, then presents the returned word, error flags and sampled external interrupts as the instruction-SRAM data that fetch consumes. While a fetch is in flight it requests a pipeline stall. It absorbs flushes and exceptions without violating AXI handshake rules.

Parameters:
AXI_ID, 4'd0, constant ARID driven on every request.
RESET_PC, 32'hBFC0_0000, address used only by the bench for first-fetch checks; no RTL effect beyond documentation.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  1  fetch request valid from pc_reg
addr  in  32  virtual fetch address
stall  in  1  pipeline stall; delivered instruction must be held
flush  in  1  exception/ERET flush; discard in-flight fetch
ext_int_i  in  6  external interrupt lines
instr  out  32  fetched instruction
instr_valid  out  1  instr corresponds to current req
addr_err  out  1  addr[1:0]!=0 (AdEL on fetch)
bus_err  out  1  RRESP != OKAY
ext_int_o  out  6  ext_int_i registered one cycle
stall_req  out  1  fetch not complete; freeze PC and upstream
arid  out  4  = AXI_ID
araddr  out  32  physical address
arlen  out  8  constant 0
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored (single outstanding)
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset: state IDLE. instr, instr_valid, addr_err, bus_err, ext_int_o, arvalid, rready and araddr are all 0. Constant AR fields are driven at all times.
- States: IDLE, AR, R, DRAIN, DONE. Only one transaction is outstanding at a time.
- IDLE, req=1, flush=0, addr[1:0]==0: latch physical address and go to AR. arvalid=1 from the next cycle.
- IDLE, req=1, flush=0, addr[1:0]!=0: no bus access. Go to DONE with instr=0 and addr_err=1.
- Address map: addr[31:29] of 3'b100 or 3'b101 (kseg0/kseg1) gives araddr={3'b000,addr[28:0]}. All other addresses pass through unchanged.
- AR: hold arvalid and araddr stable until arready. On handshake go to R, or to DRAIN if a flush occurred during AR (flush is recorded in a sticky flag). arvalid is never withdrawn early.
- R: rready=1. On rvalid&rlast: if flush is high this cycle, go to IDLE and discard the beat. Otherwise capture rdata, set bus_err=(rresp!=2'b00) and go to DONE. If flush arrives without rvalid, go to DRAIN.
- DRAIN: rready=1. On rvalid&rlast go to IDLE and discard. No outputs update.
- DONE: instr_valid=1 and outputs are held. Exit to IDLE when stall==0 (consumed) or flush==1; instr_valid clears the next cycle.
- stall_req = req & (state != DONE), combinational. It is also asserted in IDLE on the request cycle.
- Minimum latency: req in cycle 0, arvalid in cycle 1, arready in cycle 1, rvalid in cycle 2, instr_valid in cycle 3.
- Simultaneous flush and req in IDLE: flush wins and no request is issued that cycle.
- Reset mid-transaction resets the bridge only; interconnect reset is system-level.
- ext_int_o <= ext_int_i every cycle, independent of state.

Decomposition:
- my_mips.svh: ibus_state_t enum; AXI constants (RESP_OKAY, BURST_INCR, SIZE_4B).
- inst_sram_data_t is extended with addr_err and bus_err.
- One natural sub-module: fixed_addr_map (combinational kseg0/kseg1 to physical translation), reused by the data-side bridge.

Test Plan:
- Reset, then req=1, addr=32'hBFC0_0000, arready=1, rvalid in cycle 2 with rdata=32'h2408_0001 -> araddr=32'h1FC0_0000; instr_valid in cycle 3 with instr=32'h2408_0001; stall_req low in cycle 3.
- addr=32'h8000_0002 -> no arvalid ever; DONE next cycle with addr_err=1 and instr=0.
- arready held low 5 cycles, flush pulsed in cycle 2 -> arvalid and araddr stable until handshake; state goes to DRAIN; the R beat is accepted and discarded; instr_valid stays 0.
- rresp=2'b10 with rdata=32'hDEAD_BEEF -> instr=32'hDEAD_BEEF, bus_err=1, instr_valid=1.
- DONE with stall=1 for 3 cycles -> instr and instr_valid held; on stall release, next req issues AR one cycle later.
- ext_int_i=6'b10_0001 pulsed in a single cycle -> ext_int_o=6'b10_0001 exactly one cycle later, in any state.

Source files
------------

// File: rtl/inst_axi_bridge_pkg.sv
// Shared types and AXI constants for the instruction-side bus bridge.
// Reused by the fetch stage and the data-side bridge.
package inst_axi_bridge_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DRAIN,
    S_DONE
  } ibus_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        addr_err;
    logic        bus_err;
  } inst_sram_data_t;

endpackage

// File: rtl/inst_axi_bridge_fixed_addr_map.sv
// Fixed MIPS address map: kseg0/kseg1 fold onto the low 512 MB,
// everything else passes through untranslated.
module fixed_addr_map (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (vaddr[31:30] == 2'b10)
      paddr = {3'b000, vaddr[28:0]};
  end

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction-side AXI4 read bridge: one single-beat fetch in flight,
// flush-safe, results held for fetch until consumed.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  ext_int_i,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic [5:0]  ext_int_o,
  output logic        stall_req,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  ibus_state_t     state;
  ibus_state_t     state_n;
  inst_sram_data_t data_q;
  logic            flush_seen;
  logic [31:0]     paddr;
  logic            addr_bad;
  logic            start;
  logic            beat;
  logic            unused_ok;

  fixed_addr_map u_map (
    .vaddr (addr),
    .paddr (paddr)
  );

  assign addr_bad  = |addr[1:0];
  assign start     = req && !flush;
  assign beat      = rvalid && rlast;
  assign unused_ok = ^{rid, RESET_PC};

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

  assign instr    = data_q.instr;
  assign addr_err = data_q.addr_err;
  assign bus_err  = data_q.bus_err;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = addr_bad ? S_DONE : S_AR;
      S_AR:
        if (arready)
          state_n = (flush_seen || flush) ? S_DRAIN : S_R;
      S_R:
        if (beat)       state_n = flush ? S_IDLE : S_DONE;
        else if (flush) state_n = S_DRAIN;
      S_DRAIN:
        if (beat) state_n = S_IDLE;
      S_DONE:
        if (!stall || flush) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid     = (state == S_AR);
    rready      = (state == S_R) || (state == S_DRAIN);
    instr_valid = (state == S_DONE);
    stall_req   = req && (state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr     <= '0;
      data_q     <= '0;
      flush_seen <= 1'b0;
      ext_int_o  <= '0;
    end else begin
      ext_int_o <= ext_int_i;
      // Flush during AR cannot cancel the address; remember it.
      if (state == S_IDLE)
        flush_seen <= 1'b0;
      else if (state == S_AR && flush)
        flush_seen <= 1'b1;
      if (state == S_IDLE && start) begin
        if (addr_bad)
          data_q <= '{instr: '0, addr_err: 1'b1, bus_err: 1'b0};
        else
          araddr <= paddr;
      end
      if (state == S_R && beat && !flush)
        data_q <= '{instr: rdata, addr_err: 1'b0,
                    bus_err: (rresp != RESP_OKAY)};
    end
  end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge with a result scoreboard.
module tb_inst_axi_bridge;
  import inst_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        flush;
  logic [5:0]  ext_int_i;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic        bus_err;
  logic [5:0]  ext_int_o;
  logic        stall_req;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  inst_sram_data_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  inst_axi_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .addr        (addr),
    .stall       (stall),
    .flush       (flush),
    .ext_int_i   (ext_int_i),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .bus_err     (bus_err),
    .ext_int_o   (ext_int_o),
    .stall_req   (stall_req),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic sb_pop(input string tag);
    inst_sram_data_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed result with empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.instr);
      chk({tag, "_aerr"}, {31'd0, addr_err}, {31'd0, e.addr_err});
      chk({tag, "_berr"}, {31'd0, bus_err}, {31'd0, e.bus_err});
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; stall = 1'b0; flush = 1'b0;
    ext_int_i = '0; arready = 1'b0; rid = '0; rdata = '0;
    rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_aerr", addr_err, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_extint", ext_int_o, 0);
    chk("rst_arsize", arsize, 3'b010);
    chk("rst_arburst", arburst, 2'b01);
    chk("rst_arlen", arlen, 0);
    chk("rst_arid", arid, 0);
    @(negedge clk); rst = 1'b0;

    // Minimum-latency fetch from the reset vector
    @(negedge clk);
    req = 1'b1; addr = 32'hBFC0_0000; arready = 1'b1;
    sb.push_back('{instr: 32'h2408_0001, addr_err: 1'b0, bus_err: 1'b0});
    #1 chk("t1_stall_c0", stall_req, 1);
    chk("t1_arvalid_c0", arvalid, 0);
    @(negedge clk); #1;
    chk("t1_arvalid_c1", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    @(negedge clk);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h2408_0001; rresp = 2'b00;
    #1 chk("t1_rready_c2", rready, 1);
    chk("t1_ivalid_c2", instr_valid, 0);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t1_ivalid_c3", instr_valid, 1);
    chk("t1_stall_c3", stall_req, 0);
    sb_pop("t1");
    req = 1'b0;
    @(negedge clk); #1 chk("t1_ivalid_clr", instr_valid, 0);

    // Misaligned fetch: no bus access
    @(negedge clk);
    req = 1'b1; addr = 32'h8000_0002;
    sb.push_back('{instr: 32'h0, addr_err: 1'b1, bus_err: 1'b0});
    #1 chk("t2_arvalid_c0", arvalid, 0);
    @(negedge clk); #1;
    chk("t2_ivalid", instr_valid, 1);
    chk("t2_arvalid_c1", arvalid, 0);
    sb_pop("t2");
    req = 1'b0;
    @(negedge clk); #1;
    chk("t2_arvalid_c2", arvalid, 0);
    chk("t2_ivalid_clr", instr_valid, 0);

    // AR stall with flush in cycle 2, then drain
    @(negedge clk);
    req = 1'b1; addr = 32'hBFC0_0004; arready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2) begin flush = 1'b1; req = 1'b0; end
      if (i == 3) begin flush = 1'b0; ext_int_i = 6'b10_0001; end
      if (i == 4) ext_int_i = 6'b00_0000;
      #1 chk("t3_arvalid_hold", arvalid, 1);
      chk("t3_araddr_hold", araddr, 32'h1FC0_0004);
      if (i == 4) chk("t3_extint_on", ext_int_o, 6'b10_0001);
      if (i == 5) chk("t3_extint_off", ext_int_o, 6'b00_0000);
    end
    @(negedge clk);
    arready = 1'b1;
    #1 chk("t3_arvalid_hs", arvalid, 1);
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1111_2222; rresp = 2'b00;
    #1 chk("t3_arvalid_drain", arvalid, 0);
    chk("t3_rready_drain", rready, 1);
    chk("t3_ivalid_drain", instr_valid, 0);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t3_rready_idle", rready, 0);
    chk("t3_ivalid_idle", instr_valid, 0);
    @(negedge clk); #1 chk("t3_ivalid_after", instr_valid, 0);

    // Bus error, held under stall, then back-to-back fetch
    @(negedge clk);
    req = 1'b1; addr = 32'h0000_1000; arready = 1'b1;
    sb.push_back('{instr: 32'hDEAD_BEEF, addr_err: 1'b0, bus_err: 1'b1});
    @(negedge clk); #1;
    chk("t4_arvalid", arvalid, 1);
    chk("t4_araddr", araddr, 32'h0000_1000);
    @(negedge clk);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; stall = 1'b1;
    #1 chk("t4_ivalid", instr_valid, 1);
    sb_pop("t4");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t5_ivalid_hold", instr_valid, 1);
      chk("t5_instr_hold", instr, 32'hDEAD_BEEF);
      chk("t5_berr_hold", bus_err, 1);
    end
    @(negedge clk);
    stall = 1'b0; addr = 32'hA000_0010;
    sb.push_back('{instr: 32'h3C01_1234, addr_err: 1'b0, bus_err: 1'b0});
    #1 chk("t5_ivalid_rel", instr_valid, 1);
    chk("t5_stall_rel", stall_req, 0);
    @(negedge clk); #1;
    chk("t5_arvalid_idle", arvalid, 0);
    chk("t5_stall_idle", stall_req, 1);
    @(negedge clk); #1;
    chk("t5_arvalid_next", arvalid, 1);
    chk("t5_araddr_next", araddr, 32'h0000_0010);
    @(negedge clk);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h3C01_1234; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t5_ivalid_next", instr_valid, 1);
    sb_pop("t5");
    req = 1'b0;

    // Flush coincident with the R beat discards it
    @(negedge clk);
    req = 1'b1; addr = 32'h8000_0100; arready = 1'b1;
    @(negedge clk); #1;
    chk("t6_arvalid", arvalid, 1);
    chk("t6_araddr", araddr, 32'h0000_0100);
    @(negedge clk);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_AAAA;
    flush = 1'b1; req = 1'b0;
    #1 chk("t6_rready", rready, 1);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; flush = 1'b0;
    #1 chk("t6_ivalid", instr_valid, 0);
    chk("t6_rready_idle", rready, 0);

    // Flush beats req in IDLE
    @(negedge clk);
    req = 1'b1; flush = 1'b1; addr = 32'hBFC0_0000;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    #1 chk("t7_arvalid", arvalid, 0);
    chk("t7_ivalid", instr_valid, 0);

    // Interrupt pulse while idle
    @(negedge clk); ext_int_i = 6'b10_0001;
    @(negedge clk); ext_int_i = 6'b00_0000;
    #1 chk("t8_extint_on", ext_int_o, 6'b10_0001);
    @(negedge clk); #1 chk("t8_extint_off", ext_int_o, 6'b00_0000);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
